// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response to APB master bridge.
// Misaligned requests complete with an error without touching the bus; stalled slaves time out.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        prstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  input  logic [31:0] prdata,
  input  logic        pready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic [31:0] r_paddr, w_paddr_nxt;
  logic [31:0] r_pwdata, w_pwdata_nxt;
  logic        r_pwrite, w_pwrite_nxt;
  logic        r_psel, w_psel_nxt;
  logic        r_penable, w_penable_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;

  // State and registered-output update.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 8'd0;
      r_paddr     <= 32'd0;
      r_pwdata    <= 32'd0;
      r_pwrite    <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next-state and next-output decode; response fields default to zero so they pulse for one cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_pwrite_nxt    = r_pwrite;
    w_psel_nxt      = 1'b0;
    w_penable_nxt   = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = 32'd0;
    w_rsp_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_paddr_nxt  = req_addr;
          w_pwdata_nxt = req_wdata;
          w_pwrite_nxt = req_write;
          if (req_addr[1:0] != 2'b00) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt    = ST_SETUP;
            w_psel_nxt     = 1'b1;
            w_wait_cnt_nxt = 8'd0;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_pwrite ? 32'd0 : prdata;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_psel_nxt     = 1'b1;
          w_penable_nxt  = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pwrite    = r_pwrite;
  assign psel      = r_psel;
  assign penable   = r_penable;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small 4-word APB slave model.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        prstn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready;
  logic        slv_ready;
  logic [31:0] mem [0:3];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.TIMEOUT(16)) dut (
    .pclk(pclk), .prstn(prstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .prdata(prdata), .pready(pready)
  );

  assign pready = slv_ready;
  assign prdata = mem[paddr[3:2]];

  // Slave register file with fixed reset contents.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      mem[0] <= 32'h0000_002C;
      mem[1] <= 32'h0000_FACE;
      mem[2] <= 32'hF000_DA7A;
      mem[3] <= 32'h0000_0000;
    end else if (psel && penable && pready && pwrite) begin
      mem[paddr[3:2]] <= pwdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic xfer(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                      input logic wr, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    req_valid = 1'b1; req_addr = addr; req_wdata = wd; req_write = wr;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    tick();
  endtask

  initial begin
    prstn = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_write = 1'b0; slv_ready = 1'b1;
    tick(); tick();
    check("rst_psel", {31'd0, psel}, 32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    prstn = 1'b1;
    tick();

    // Single read of 0x0 with phase-by-phase checks.
    req_valid = 1'b1; req_addr = 32'h0; req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    check("rd0_setup", {30'd0, psel, penable}, 32'd2);
    check("rd0_setup_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("rd0_access", {30'd0, psel, penable}, 32'd3);
    tick();
    check("rd0_done_bus", {30'd0, psel, penable}, 32'd0);
    check("rd0_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
    check("rd0_rdata", rsp_rdata, 32'h0000_002C);
    check("rd0_ready", {31'd0, req_ready}, 32'd1);
    tick();
    check("rd0_pulse", {31'd0, rsp_valid}, 32'd0);
    check("rd0_rdata_zero", rsp_rdata, 32'd0);

    // Back-to-back reads with req_valid held.
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    check("b2b_setup1", {30'd0, psel, penable}, 32'd2);
    tick();
    check("b2b_paddr1", paddr, 32'h4);
    req_addr = 32'h8;
    tick();
    check("b2b_rdata1", rsp_rdata, 32'h0000_FACE);
    check("b2b_idle", {31'd0, psel}, 32'd0);
    tick();
    check("b2b_setup2", {30'd0, psel, penable}, 32'd2);
    check("b2b_paddr2", paddr, 32'h8);
    check("b2b_rsp_gone", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    tick(); tick();
    check("b2b_rdata2", rsp_rdata, 32'hF000_DA7A);
    check("b2b_valid2", {31'd0, rsp_valid}, 32'd1);
    tick();

    // Write then read back, pwrite held through the write.
    req_valid = 1'b1; req_addr = 32'h8; req_wdata = 32'h1234; req_write = 1'b1;
    tick();
    req_valid = 1'b0;
    check("wr_setup_pwrite", {31'd0, pwrite}, 32'd1);
    check("wr_pwdata", pwdata, 32'h1234);
    tick();
    check("wr_access_pwrite", {31'd0, pwrite}, 32'd1);
    tick();
    check("wr_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
    check("wr_rdata", rsp_rdata, 32'd0);
    tick();
    xfer("rd8", 32'h8, 32'd0, 1'b0, 32'h1234, 1'b0);

    // Misaligned request: error response, no bus cycle.
    req_valid = 1'b1; req_addr = 32'h2; req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    check("mis_psel", {31'd0, psel}, 32'd0);
    check("mis_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
    check("mis_rdata", rsp_rdata, 32'd0);
    tick();
    check("mis_psel2", {31'd0, psel}, 32'd0);
    check("mis_pulse", {31'd0, rsp_valid}, 32'd0);

    // Timeout: ACCESS lasts exactly 16 cycles.
    slv_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    n = 0;
    while (psel && penable && n < 100) begin
      n++;
      tick();
    end
    check("to_access_len", 32'(n), 32'd16);
    check("to_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
    check("to_rdata", rsp_rdata, 32'd0);
    check("to_psel", {31'd0, psel}, 32'd0);
    slv_ready = 1'b1;
    tick();

    // Asynchronous reset during ACCESS.
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    check("ar_access", {30'd0, psel, penable}, 32'd3);
    #2 prstn = 1'b0;
    #1;
    check("ar_bus_low", {30'd0, psel, penable}, 32'd0);
    check("ar_no_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    prstn = 1'b1;
    tick();
    check("ar_after_rsp", {31'd0, rsp_valid}, 32'd0);
    xfer("ar_rd0", 32'h0, 32'd0, 1'b0, 32'h0000_002C, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
